alu_control_pipe: RTL and testbench
===================================

# alu_control_pipe

Registered, handshaked successor to the combinational ALU control decoder. It decodes `alu_op` and `func` into the ALU control code and the JR mux select, and registers them into the EX stage. It also sequences multi-cycle multiply/divide operations with an interlock that stalls the issue stage. It sits between the ID/EX pipeline register and the ALU/MDU.

## Interface
- `CTRL_W`, 4: ALU control code width; must be ≥4.
- `OP_W`, 3: `alu_op` width from the main control unit.
- `MDU_CYCLES`, 32: iterative multiply/divide latency in cycles; must be ≥1.
- `clk`  in  1  single clock; everything samples on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `valid_in`  in  1  decode request present.
- `alu_op`  in  OP_W  instruction class from control unit.
- `func`  in  6  R-format function field.
- `stall_in`  in  1  downstream (EX) cannot accept; hold outputs.
- `stall_out`  out  1  combinational; request not accepted this cycle, upstream must hold.
- `valid_out`  out  1  registered outputs are valid.
- `alu_ctrl`  out  CTRL_W  registered ALU control code.
- `jr_sel`  out  1  registered; 1 selects the JR target address.
- `illegal_op`  out  1  registered; the accepted encoding is undefined.
- `mdu_start`  out  1  one-cycle pulse; start the MDU.
- `mdu_busy`  out  1  MDU sequence in progress.
- `mdu_done`  out  1  one-cycle pulse; HI/LO results valid.

## Operation
- Accept condition: `accept = valid_in & ~stall_in & ~interlock`. `stall_out = valid_in & (stall_in | interlock)`.
- `interlock` is 1 when the state is BUSY and the request is an MDU op (mult/multu/div/divu) or mfhi/mflo. All other ops proceed while BUSY.
- R-format decode (`alu_op`=2):
  - add (32) → 2; sub (34) → 6; and (36) → 0; or (37) → 1; nor (39) → 12; slt (42) → 7; sll (0) → 13.
  - jr (8) → `jr_sel`=1 with `alu_ctrl`=2.
  - mult (24) → 8; multu (25) → 9; div (26) → 10; divu (27) → 11; mfhi (16) → 14; mflo (18) → 15.
- Non-R decode:
  - `alu_op`=0 (lw/sw) → 2; 1 (beq) → 6; 3 (ori) → 1; 4 (sll) → 13; 5 (slti) → 7; 6 (andi) → 0.
- Undefined `func` or `alu_op` → `alu_ctrl`=0, `illegal_op`=1. An illegal op never starts the MDU.
- `jr_sel` is 1 only for `alu_op`=2 and `func`=8.
- Output register update rules:
  - On accept, load the decode result and set `valid_out`=1.
  - If `stall_in`, hold all registered outputs.
  - Otherwise, with no accept, set `valid_out`=0; `alu_ctrl`, `jr_sel` and `illegal_op` hold their last value.
- MDU FSM, states IDLE, BUSY, DONE:
  - IDLE: an accepted MDU op moves to BUSY, loads counter=MDU_CYCLES-1 and pulses `mdu_start`.
  - BUSY: the counter decrements each cycle. At counter=0, move to DONE.
  - DONE: pulse `mdu_done`. An accepted MDU op in this cycle goes directly to BUSY with a new `mdu_start`; otherwise return to IDLE.
- `mdu_busy` = (state==BUSY). The counter is ⌈log2(MDU_CYCLES)⌉ bits and never wraps; counter=0 is the exit condition.

## Timing
- Decode latency: 1 cycle, accept edge to `valid_out`.
- An MDU op accepted at edge N:
  - `mdu_start` and `mdu_busy` are high from N+1.
  - `mdu_busy` stays high for MDU_CYCLES cycles.
  - `mdu_done` is high in cycle N+1+MDU_CYCLES.
  - mfhi/mflo presented during BUSY is accepted in the DONE cycle.
- Simultaneous `stall_in` and interlock: not accepted; `stall_out`=1; no state change beyond counter progress.
- Reset values:
  - `valid_out`, `jr_sel`, `illegal_op`, `mdu_start`, `mdu_busy` and `mdu_done` are 0; `alu_ctrl`=0.
  - State is IDLE and counter=0.
- Reset mid-sequence aborts it: `mdu_busy` is 0 after the reset edge and no `mdu_done` is emitted.

## Configuration
- `ALU_CTRL_MDU_EN` defined: the MDU FSM, interlock and MDU decodes are present as described above.
- Not defined:
  - func 24/25/26/27/16/18 decode as illegal.
  - `mdu_start`, `mdu_busy` and `mdu_done` are tied 0.
  - `interlock`=0, so `stall_out` reduces to `valid_in & stall_in`.

## Structure
- Shared package `alu_ctrl_pkg` holds:
  - the ALU control code constants (ADD=2, SUB=6, AND=0, OR=1, SLT=7, NOR=12, SLL=13, MULT=8 … MFLO=15);
  - the func constants and the `alu_op` constants;
  - the MDU state enum.
- Sub-module `mdu_sequencer` contains the FSM and counter. Inputs: `clk`, `reset`, `start_req`. Outputs: `busy`, `start`, `done`.

## Test plan
- Reset, then `alu_op`=2 with func 32, 34, 37, 42, 39 back-to-back → `alu_ctrl` 2, 6, 1, 7, 12 one cycle later each; `valid_out` continuously 1.
- `alu_op`=2, func=8 → `jr_sel`=1, `alu_ctrl`=2. Next op lw (`alu_op`=0) → `jr_sel`=0, `alu_ctrl`=2.
- MDU_CYCLES=4: mult accepted at edge 0 → `mdu_start` in cycle 1, `mdu_busy` in cycles 1–4, `mdu_done` in cycle 5. An add issued in cycle 2 is accepted with `stall_out`=0.
- mflo presented in cycle 2 of a BUSY sequence → `stall_out`=1 in cycles 2–4, accepted in cycle 5, `alu_ctrl`=15 in cycle 6.
- `stall_in` held 3 cycles while `valid_out`=1 → outputs frozen. `alu_op`=7 → `alu_ctrl`=0, `illegal_op`=1, no `mdu_start`.
- `reset` asserted in cycle 2 of a div → `mdu_busy`=0 from cycle 3 and no `mdu_done`. Rebuilding without `ALU_CTRL_MDU_EN` → mult yields `illegal_op`=1.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the registered ALU control decoder: ALU control codes,
// R-format function codes, alu_op classes and the MDU sequencer state encoding.
package alu_ctrl_pkg;

    localparam int unsigned CTRL_AND   = 0;
    localparam int unsigned CTRL_OR    = 1;
    localparam int unsigned CTRL_ADD   = 2;
    localparam int unsigned CTRL_SUB   = 6;
    localparam int unsigned CTRL_SLT   = 7;
    localparam int unsigned CTRL_MULT  = 8;
    localparam int unsigned CTRL_MULTU = 9;
    localparam int unsigned CTRL_DIV   = 10;
    localparam int unsigned CTRL_DIVU  = 11;
    localparam int unsigned CTRL_NOR   = 12;
    localparam int unsigned CTRL_SLL   = 13;
    localparam int unsigned CTRL_MFHI  = 14;
    localparam int unsigned CTRL_MFLO  = 15;

    localparam logic [5:0] FUNC_SLL   = 6'd0;
    localparam logic [5:0] FUNC_JR    = 6'd8;
    localparam logic [5:0] FUNC_MFHI  = 6'd16;
    localparam logic [5:0] FUNC_MFLO  = 6'd18;
    localparam logic [5:0] FUNC_MULT  = 6'd24;
    localparam logic [5:0] FUNC_MULTU = 6'd25;
    localparam logic [5:0] FUNC_DIV   = 6'd26;
    localparam logic [5:0] FUNC_DIVU  = 6'd27;
    localparam logic [5:0] FUNC_ADD   = 6'd32;
    localparam logic [5:0] FUNC_SUB   = 6'd34;
    localparam logic [5:0] FUNC_AND   = 6'd36;
    localparam logic [5:0] FUNC_OR    = 6'd37;
    localparam logic [5:0] FUNC_NOR   = 6'd39;
    localparam logic [5:0] FUNC_SLT   = 6'd42;

    localparam int unsigned OP_LWSW  = 0;
    localparam int unsigned OP_BEQ   = 1;
    localparam int unsigned OP_RTYPE = 2;
    localparam int unsigned OP_ORI   = 3;
    localparam int unsigned OP_SLL   = 4;
    localparam int unsigned OP_SLTI  = 5;
    localparam int unsigned OP_ANDI  = 6;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer: down-counter from MDU_CYCLES-1, exits on zero.
// state    | meaning
// IDLE     | no MDU operation in flight
// BUSY     | MDU iterating, counter counts down to zero
// DONE     | HI/LO valid this cycle; may restart back-to-back
module mdu_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int MDU_CYCLES = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic start_req,
    output logic busy,
    output logic start,
    output logic done
);

    localparam int CNT_W = (MDU_CYCLES > 1) ? $clog2(MDU_CYCLES) : 1;

    mdu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             start_q;
    logic             done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                MDU_IDLE: begin
                    if (start_req) begin
                        state_q <= MDU_BUSY;
                        cnt_q   <= CNT_W'(MDU_CYCLES - 1);
                        start_q <= 1'b1;
                    end
                end
                MDU_BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= MDU_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                MDU_DONE: begin
                    if (start_req) begin
                        state_q <= MDU_BUSY;
                        cnt_q   <= CNT_W'(MDU_CYCLES - 1);
                        start_q <= 1'b1;
                    end else begin
                        state_q <= MDU_IDLE;
                    end
                end
                default: state_q <= MDU_IDLE;
            endcase
        end
    end

    assign busy  = (state_q == MDU_BUSY);
    assign start = start_q;
    assign done  = done_q;

endmodule

// File: rtl/alu_control_pipe.sv
// Registered ALU control decoder with EX-stage handshake and MDU interlock.
// Optional feature macro: ALU_CTRL_MDU_EN (MDU decodes, sequencer and interlock).
module alu_control_pipe
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W     = 4,
    parameter int OP_W       = 3,
    parameter int MDU_CYCLES = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [OP_W-1:0]   alu_op,
    input  logic [5:0]        func,
    input  logic              stall_in,
    output logic              stall_out,
    output logic              valid_out,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              jr_sel,
    output logic              illegal_op,
    output logic              mdu_start,
    output logic              mdu_busy,
    output logic              mdu_done
);

    if (CTRL_W < 4 || MDU_CYCLES < 1) begin : g_bad_params
        $error("alu_control_pipe: CTRL_W must be >= 4 and MDU_CYCLES >= 1");
    end

    logic [CTRL_W-1:0] ctrl_d, ctrl_q;
    logic              jr_d, jr_q;
    logic              ill_d, ill_q;
    logic              valid_q;
    logic              interlock;
    logic              accept;
`ifdef ALU_CTRL_MDU_EN
    logic              mdu_op_d;
    logic              hilo_op_d;
`endif

    always_comb begin
        ctrl_d = '0;
        jr_d   = 1'b0;
        ill_d  = 1'b0;
`ifdef ALU_CTRL_MDU_EN
        mdu_op_d  = 1'b0;
        hilo_op_d = 1'b0;
`endif
        case (alu_op)
            OP_W'(OP_LWSW): ctrl_d = CTRL_W'(CTRL_ADD);
            OP_W'(OP_BEQ):  ctrl_d = CTRL_W'(CTRL_SUB);
            OP_W'(OP_ORI):  ctrl_d = CTRL_W'(CTRL_OR);
            OP_W'(OP_SLL):  ctrl_d = CTRL_W'(CTRL_SLL);
            OP_W'(OP_SLTI): ctrl_d = CTRL_W'(CTRL_SLT);
            OP_W'(OP_ANDI): ctrl_d = CTRL_W'(CTRL_AND);
            OP_W'(OP_RTYPE): begin
                case (func)
                    FUNC_ADD: ctrl_d = CTRL_W'(CTRL_ADD);
                    FUNC_SUB: ctrl_d = CTRL_W'(CTRL_SUB);
                    FUNC_AND: ctrl_d = CTRL_W'(CTRL_AND);
                    FUNC_OR:  ctrl_d = CTRL_W'(CTRL_OR);
                    FUNC_NOR: ctrl_d = CTRL_W'(CTRL_NOR);
                    FUNC_SLT: ctrl_d = CTRL_W'(CTRL_SLT);
                    FUNC_SLL: ctrl_d = CTRL_W'(CTRL_SLL);
                    FUNC_JR: begin
                        ctrl_d = CTRL_W'(CTRL_ADD);
                        jr_d   = 1'b1;
                    end
`ifdef ALU_CTRL_MDU_EN
                    FUNC_MULT:  begin ctrl_d = CTRL_W'(CTRL_MULT);  mdu_op_d = 1'b1; end
                    FUNC_MULTU: begin ctrl_d = CTRL_W'(CTRL_MULTU); mdu_op_d = 1'b1; end
                    FUNC_DIV:   begin ctrl_d = CTRL_W'(CTRL_DIV);   mdu_op_d = 1'b1; end
                    FUNC_DIVU:  begin ctrl_d = CTRL_W'(CTRL_DIVU);  mdu_op_d = 1'b1; end
                    FUNC_MFHI:  begin ctrl_d = CTRL_W'(CTRL_MFHI);  hilo_op_d = 1'b1; end
                    FUNC_MFLO:  begin ctrl_d = CTRL_W'(CTRL_MFLO);  hilo_op_d = 1'b1; end
`endif
                    default: ill_d = 1'b1;
                endcase
            end
            default: ill_d = 1'b1;
        endcase
    end

`ifdef ALU_CTRL_MDU_EN
    // Only MDU ops and HI/LO reads wait for the sequencer; everything else flows past it.
    assign interlock = mdu_busy & (mdu_op_d | hilo_op_d);

    mdu_sequencer #(
        .MDU_CYCLES (MDU_CYCLES)
    ) u_mdu_sequencer (
        .clk       (clk),
        .reset     (reset),
        .start_req (accept & mdu_op_d),
        .busy      (mdu_busy),
        .start     (mdu_start),
        .done      (mdu_done)
    );
`else
    assign interlock = 1'b0;
    assign mdu_start = 1'b0;
    assign mdu_busy  = 1'b0;
    assign mdu_done  = 1'b0;
`endif

    assign accept    = valid_in & ~stall_in & ~interlock;
    assign stall_out = valid_in & (stall_in | interlock);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            jr_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else if (stall_in) begin
            valid_q <= valid_q;
        end else if (accept) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_d;
            jr_q    <= jr_d;
            ill_q   <= ill_d;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign valid_out  = valid_q;
    assign alu_ctrl   = ctrl_q;
    assign jr_sel     = jr_q;
    assign illegal_op = ill_q;

endmodule

// File: tb/tb_alu_control_pipe.sv
// Scoreboard bench for alu_control_pipe with MDU_CYCLES=4; MDU checks follow ALU_CTRL_MDU_EN.
module tb_alu_control_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_in;
    logic [2:0] alu_op;
    logic [5:0] func;
    logic       stall_in;
    logic       stall_out;
    logic       valid_out;
    logic [3:0] alu_ctrl;
    logic       jr_sel;
    logic       illegal_op;
    logic       mdu_start;
    logic       mdu_busy;
    logic       mdu_done;

    int checks = 0;
    int errors = 0;

    logic [5:0] exp_q[$];
    logic [5:0] mon_e;

    alu_control_pipe #(
        .CTRL_W     (4),
        .OP_W       (3),
        .MDU_CYCLES (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (valid_in),
        .alu_op     (alu_op),
        .func       (func),
        .stall_in   (stall_in),
        .stall_out  (stall_out),
        .valid_out  (valid_out),
        .alu_ctrl   (alu_ctrl),
        .jr_sel     (jr_sel),
        .illegal_op (illegal_op),
        .mdu_start  (mdu_start),
        .mdu_busy   (mdu_busy),
        .mdu_done   (mdu_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait (bounded) until it is accepted, and record its expected result.
    task automatic issue(input logic [2:0] op, input logic [5:0] f,
                         input logic [3:0] ectrl, input logic ejr, input logic eill);
        int n;
        valid_in = 1'b1;
        alu_op   = op;
        func     = f;
        #1;
        n = 0;
        while (stall_out && n < 50) begin
            tick();
            n++;
        end
        if (stall_out) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: op %0d func %0d still stalled", op, f);
        end
        exp_q.push_back({ectrl, ejr, eill});
        tick();
        valid_in = 1'b0;
    endtask

    // EX consumes a result on every edge where valid_out is high and it is not stalling.
    always @(negedge clk) begin
        if (!reset && valid_out === 1'b1 && !stall_in) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got ctrl %0d with empty scoreboard", alu_ctrl);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_ctrl", 32'(alu_ctrl), 32'(mon_e[5:2]));
                chk("out_jr", 32'(jr_sel), 32'(mon_e[1]));
                chk("out_illegal", 32'(illegal_op), 32'(mon_e[0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    logic [5:0] rf[5] = '{6'd32, 6'd34, 6'd37, 6'd42, 6'd39};
    logic [3:0] rc[5] = '{4'd2, 4'd6, 4'd1, 4'd7, 4'd12};

    // {alu_op, func, ctrl, jr, illegal}
    logic [14:0] vec[12] = '{
        {3'd2, 6'd36, 4'd0,  1'b0, 1'b0},
        {3'd2, 6'd0,  4'd13, 1'b0, 1'b0},
        {3'd0, 6'd5,  4'd2,  1'b0, 1'b0},
        {3'd1, 6'd0,  4'd6,  1'b0, 1'b0},
        {3'd3, 6'd0,  4'd1,  1'b0, 1'b0},
        {3'd4, 6'd0,  4'd13, 1'b0, 1'b0},
        {3'd5, 6'd0,  4'd7,  1'b0, 1'b0},
        {3'd6, 6'd0,  4'd0,  1'b0, 1'b0},
        {3'd2, 6'd8,  4'd2,  1'b1, 1'b0},
        {3'd0, 6'd0,  4'd2,  1'b0, 1'b0},
        {3'd2, 6'd63, 4'd0,  1'b0, 1'b1},
        {3'd7, 6'd0,  4'd0,  1'b0, 1'b1}
    };

    initial begin
        logic [14:0] v;
        reset    = 1'b1;
        valid_in = 1'b0;
        alu_op   = '0;
        func     = '0;
        stall_in = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_ctrl", 32'(alu_ctrl), 0);
        chk("rst_jr", 32'(jr_sel), 0);
        chk("rst_illegal", 32'(illegal_op), 0);
        chk("rst_start", 32'(mdu_start), 0);
        chk("rst_busy", 32'(mdu_busy), 0);
        chk("rst_done", 32'(mdu_done), 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            issue(3'd2, rf[i], rc[i], 1'b0, 1'b0);
            chk("b2b_valid", 32'(valid_out), 1);
        end
        tick();
        chk("idle_valid_low", 32'(valid_out), 0);

        for (int i = 0; i < 12; i++) begin
            v = vec[i];
            issue(v[14:12], v[11:6], v[5:2], v[1], v[0]);
            chk("no_mdu_start", 32'(mdu_start), 0);
        end
        tick();

        // EX stall for 3 cycles: outputs frozen, upstream held.
        issue(3'd2, 6'd32, 4'd2, 1'b0, 1'b0);
        stall_in = 1'b1;
        valid_in = 1'b1;
        alu_op   = 3'd2;
        func     = 6'd34;
        #1;
        chk("stall_out_hi", 32'(stall_out), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frozen_valid", 32'(valid_out), 1);
            chk("frozen_ctrl", 32'(alu_ctrl), 2);
            chk("stall_out_hold", 32'(stall_out), 1);
        end
        stall_in = 1'b0;
        #1;
        chk("stall_out_release", 32'(stall_out), 0);
        exp_q.push_back({4'd6, 1'b0, 1'b0});
        tick();
        valid_in = 1'b0;
        tick();

`ifdef ALU_CTRL_MDU_EN
        // mult accepted at edge 0, add issued in cycle 2 flows past the busy MDU.
        issue(3'd2, 6'd24, 4'd8, 1'b0, 1'b0);
        chk("c1_start", 32'(mdu_start), 1);
        chk("c1_busy", 32'(mdu_busy), 1);
        tick();
        chk("c2_start", 32'(mdu_start), 0);
        chk("c2_busy", 32'(mdu_busy), 1);
        valid_in = 1'b1;
        alu_op   = 3'd2;
        func     = 6'd32;
        #1;
        chk("c2_add_stall", 32'(stall_out), 0);
        issue(3'd2, 6'd32, 4'd2, 1'b0, 1'b0);
        chk("c3_busy", 32'(mdu_busy), 1);
        tick();
        chk("c4_busy", 32'(mdu_busy), 1);
        chk("c4_done", 32'(mdu_done), 0);
        tick();
        chk("c5_busy", 32'(mdu_busy), 0);
        chk("c5_done", 32'(mdu_done), 1);
        tick();
        chk("c6_done", 32'(mdu_done), 0);
        tick();

        // mflo during BUSY waits for the DONE cycle.
        issue(3'd2, 6'd24, 4'd8, 1'b0, 1'b0);
        tick();
        valid_in = 1'b1;
        alu_op   = 3'd2;
        func     = 6'd18;
        #1;
        for (int c = 2; c <= 4; c++) begin
            chk("mflo_interlock", 32'(stall_out), 1);
            tick();
        end
        chk("mflo_done_cycle", 32'(mdu_done), 1);
        chk("mflo_accept", 32'(stall_out), 0);
        exp_q.push_back({4'd15, 1'b0, 1'b0});
        tick();
        valid_in = 1'b0;
        chk("mflo_valid", 32'(valid_out), 1);
        chk("mflo_ctrl", 32'(alu_ctrl), 15);
        tick();

        // Reset in cycle 2 of a div aborts the sequence.
        issue(3'd2, 6'd26, 4'd10, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        chk("abort_busy", 32'(mdu_busy), 0);
        chk("abort_valid", 32'(valid_out), 0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("abort_no_done", 32'(mdu_done), 0);
        end
`else
        issue(3'd2, 6'd24, 4'd0, 1'b0, 1'b1);
        chk("nomdu_start", 32'(mdu_start), 0);
        chk("nomdu_busy", 32'(mdu_busy), 0);
        issue(3'd2, 6'd18, 4'd0, 1'b0, 1'b1);
        tick();
        chk("nomdu_done", 32'(mdu_done), 0);
`endif

        tick();
        tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
